// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: default datapath width, FSM state encoding, RV64 funct3 width codes.
package lsu_pkg;

    localparam int XLEN_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Load width/sign codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store width codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store strobes/shifted data, load extraction/extension, misalign flag.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: i_funct3/i_off select width and byte offset; i_wdata/i_rdata raw data;
//        o_wstrb/o_wdata store lanes, o_rdata formatted load, o_misalign alignment error.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]        i_funct3,
    input  logic [2:0]        i_off,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [XLEN-1:0]   i_rdata,
    output logic [XLEN/8-1:0] o_wstrb,
    output logic [XLEN-1:0]   o_wdata,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_misalign
);

    localparam int NB = XLEN / 8;
    localparam logic [NB-1:0] STRB_B = NB'(1);
    localparam logic [NB-1:0] STRB_H = NB'(3);
    localparam logic [NB-1:0] STRB_W = NB'(15);

    logic [5:0]      w_bitoff;
    logic [XLEN-1:0] w_rshift;

    assign w_bitoff = {i_off, 3'b000};
    assign o_wdata  = i_wdata << w_bitoff;
    assign w_rshift = i_rdata >> w_bitoff;

    // funct3[1:0] encodes the access size identically for loads and stores
    always_comb begin
        o_wstrb    = '0;
        o_misalign = 1'b0;
        case (i_funct3[1:0])
            2'b00: begin
                o_wstrb    = STRB_B << i_off;
            end
            2'b01: begin
                o_wstrb    = STRB_H << i_off;
                o_misalign = i_off[0];
            end
            2'b10: begin
                o_wstrb    = STRB_W << i_off;
                o_misalign = |i_off[1:0];
            end
            default: begin
                o_wstrb    = '1;
                o_misalign = |i_off;
            end
        endcase
    end

    always_comb begin
        o_rdata = '0;
        case (i_funct3)
            F3_LB:   o_rdata = {{(XLEN-8){w_rshift[7]}},   w_rshift[7:0]};
            F3_LH:   o_rdata = {{(XLEN-16){w_rshift[15]}}, w_rshift[15:0]};
            F3_LW:   o_rdata = {{(XLEN-32){w_rshift[31]}}, w_rshift[31:0]};
            F3_LD:   o_rdata = w_rshift;
            F3_LBU:  o_rdata = {{(XLEN-8){1'b0}},  w_rshift[7:0]};
            F3_LHU:  o_rdata = {{(XLEN-16){1'b0}}, w_rshift[15:0]};
            F3_LWU:  o_rdata = {{(XLEN-32){1'b0}}, w_rshift[31:0]};
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding memory op, aligned doubleword bus, sign/zero extension.
// Latency: load >= 3 cycles accept->resp_valid, store >= 2, faulting op 1 cycle.
// Backpressure: o_stall holds the core; o_mem_req held stable until i_mem_gnt.
// Ports: core side i_req_valid/i_is_load/i_is_store/i_funct3/i_addr/i_wdata ->
//        o_stall/o_resp_valid/o_load_data/o_fault; memory side o_mem_* / i_mem_*.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    input  logic              i_is_load,
    input  logic              i_is_store,
    input  logic [2:0]        i_funct3,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic              o_stall,
    output logic              o_resp_valid,
    output logic [XLEN-1:0]   o_load_data,
    output logic              o_fault,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [XLEN/8-1:0] o_mem_wstrb,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [XLEN-1:0]   i_mem_rdata
);

    lsu_state_e r_state, w_state_nxt;

    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_load_data;
    logic              r_is_store;
    logic              r_fault;

    logic              w_idle;
    logic              w_accept;
    logic              w_illegal;
    logic              w_fault;
    logic [2:0]        w_al_funct3;
    logic [2:0]        w_al_off;
    logic [XLEN/8-1:0] w_st_strb;
    logic [XLEN-1:0]   w_st_wdata;
    logic [XLEN-1:0]   w_ld_fmt;
    logic              w_misalign;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle & i_req_valid & (i_is_load | i_is_store);

    // The aligner looks at the live request while idle (to judge alignment before
    // accepting) and at the latched request for the rest of the transaction.
    assign w_al_funct3 = w_idle ? i_funct3    : r_funct3;
    assign w_al_off    = w_idle ? i_addr[2:0] : r_addr[2:0];

    assign w_illegal = (i_is_load & i_is_store)
                     | (i_is_load  & (i_funct3 == 3'b111))
                     | (i_is_store & i_funct3[2]);
    assign w_fault   = w_illegal | w_misalign;

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_funct3   (w_al_funct3),
        .i_off      (w_al_off),
        .i_wdata    (r_wdata),
        .i_rdata    (i_mem_rdata),
        .o_wstrb    (w_st_strb),
        .o_wdata    (w_st_wdata),
        .o_rdata    (w_ld_fmt),
        .o_misalign (w_misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_funct3    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_store  <= 1'b0;
            r_fault     <= 1'b0;
            r_load_data <= '0;
        end else if (w_accept) begin
            r_funct3    <= i_funct3;
            r_addr      <= i_addr;
            r_wdata     <= i_wdata;
            r_is_store  <= i_is_store;
            r_fault     <= w_fault;
            r_load_data <= '0;
        end else if ((r_state == ST_WAIT) && i_mem_rvalid) begin
            r_load_data <= w_ld_fmt;
        end
    end

    // Memory handshakes are only looked at in REQ/WAIT, so stray grants or
    // read data in IDLE/DONE (including ones from an aborted op) fall on the floor.
    always_comb begin
        w_state_nxt  = r_state;
        o_stall      = 1'b0;
        o_resp_valid = 1'b0;
        o_load_data  = '0;
        o_fault      = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_wstrb  = '0;
        case (r_state)
            ST_IDLE: begin
                o_stall = i_req_valid;
                if (w_accept) begin
                    w_state_nxt = w_fault ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                o_stall     = 1'b1;
                o_mem_req   = 1'b1;
                o_mem_we    = r_is_store;
                o_mem_addr  = {r_addr[XLEN-1:3], 3'b000};
                o_mem_wdata = r_is_store ? w_st_wdata : '0;
                o_mem_wstrb = r_is_store ? w_st_strb  : '0;
                if (i_mem_gnt) begin
                    w_state_nxt = r_is_store ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                o_stall = 1'b1;
                if (i_mem_rvalid) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                o_resp_valid = 1'b1;
                o_fault      = r_fault;
                o_load_data  = r_load_data;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, grant backpressure, reset abort.
// Latency: checks exact cycle of resp_valid per op type.
// Backpressure: holds mem_gnt low for several cycles and checks request stability.
module tb_load_store_unit;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_req_valid, i_is_load, i_is_store;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_addr, i_wdata;
    logic            o_stall, o_resp_valid, o_fault, o_mem_req, o_mem_we;
    logic [XLEN-1:0] o_load_data, o_mem_addr, o_mem_wdata;
    logic [7:0]      o_mem_wstrb;
    logic            i_mem_gnt, i_mem_rvalid;
    logic [XLEN-1:0] i_mem_rdata;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .i_is_load    (i_is_load),
        .i_is_store   (i_is_store),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_stall      (o_stall),
        .o_resp_valid (o_resp_valid),
        .o_load_data  (o_load_data),
        .o_fault      (o_fault),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wstrb  (o_mem_wstrb),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        i_req_valid = 1'b0;
        i_is_load   = 1'b0;
        i_is_store  = 1'b0;
        i_funct3    = 3'b000;
        i_addr      = '0;
        i_wdata     = '0;
    endtask

    task automatic drive_req(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [63:0] a, input logic [63:0] wd);
        i_req_valid = 1'b1;
        i_is_load   = ld;
        i_is_store  = st;
        i_funct3    = f3;
        i_addr      = a;
        i_wdata     = wd;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, ".stall"},  {63'd0, o_stall},      64'd0);
        chk({tag, ".resp"},   {63'd0, o_resp_valid}, 64'd0);
        chk({tag, ".ldata"},  o_load_data,           64'd0);
        chk({tag, ".fault"},  {63'd0, o_fault},      64'd0);
        chk({tag, ".req"},    {63'd0, o_mem_req},    64'd0);
        chk({tag, ".we"},     {63'd0, o_mem_we},     64'd0);
        chk({tag, ".maddr"},  o_mem_addr,            64'd0);
        chk({tag, ".mwdata"}, o_mem_wdata,           64'd0);
        chk({tag, ".wstrb"},  {56'd0, o_mem_wstrb},  64'd0);
    endtask

    // Called at a negedge with the DUT idle. Grant after gnt_dly idle REQ cycles;
    // a junk rvalid is presented in the grant cycle, real data the cycle after.
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [63:0] a,
                            input int gnt_dly, input logic [63:0] rdata, input logic [63:0] exp);
        drive_req(1'b1, 1'b0, f3, a, 64'd0);
        #1 chk({tag, ".stall_idle"}, {63'd0, o_stall}, 64'd1);
        @(negedge clk);
        for (int i = 0; i <= gnt_dly; i++) begin
            chk({tag, ".req"},   {63'd0, o_mem_req}, 64'd1);
            chk({tag, ".we"},    {63'd0, o_mem_we},  64'd0);
            chk({tag, ".maddr"}, o_mem_addr, {a[63:3], 3'b000});
            if (i == gnt_dly) begin
                i_mem_gnt    = 1'b1;
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = ~rdata;
            end
            @(negedge clk);
        end
        chk({tag, ".wait_resp"},  {63'd0, o_resp_valid}, 64'd0);
        chk({tag, ".wait_stall"}, {63'd0, o_stall},      64'd1);
        chk({tag, ".wait_req"},   {63'd0, o_mem_req},    64'd0);
        i_mem_gnt   = 1'b0;
        i_mem_rdata = rdata;
        @(negedge clk);
        chk({tag, ".resp"},  {63'd0, o_resp_valid}, 64'd1);
        chk({tag, ".ldata"}, o_load_data,           exp);
        chk({tag, ".fault"}, {63'd0, o_fault},      64'd0);
        chk({tag, ".stall"}, {63'd0, o_stall},      64'd0);
        idle_inputs();
        i_mem_rvalid = 1'b0;
        @(negedge clk);
        chk({tag, ".resp_drop"}, {63'd0, o_resp_valid}, 64'd0);
    endtask

    task automatic run_store(input string tag, input logic [2:0] f3, input logic [63:0] a,
                             input logic [63:0] wd, input int gnt_dly,
                             input logic [7:0] exp_strb, input logic [63:0] exp_wd);
        drive_req(1'b0, 1'b1, f3, a, wd);
        #1 chk({tag, ".stall_idle"}, {63'd0, o_stall}, 64'd1);
        @(negedge clk);
        for (int i = 0; i <= gnt_dly; i++) begin
            chk({tag, ".req"},    {63'd0, o_mem_req},    64'd1);
            chk({tag, ".we"},     {63'd0, o_mem_we},     64'd1);
            chk({tag, ".maddr"},  o_mem_addr,            {a[63:3], 3'b000});
            chk({tag, ".mwdata"}, o_mem_wdata,           exp_wd);
            chk({tag, ".wstrb"},  {56'd0, o_mem_wstrb},  {56'd0, exp_strb});
            chk({tag, ".stall"},  {63'd0, o_stall},      64'd1);
            chk({tag, ".noresp"}, {63'd0, o_resp_valid}, 64'd0);
            if (i == gnt_dly) i_mem_gnt = 1'b1;
            @(negedge clk);
        end
        chk({tag, ".resp"},       {63'd0, o_resp_valid}, 64'd1);
        chk({tag, ".done_stall"}, {63'd0, o_stall},      64'd0);
        chk({tag, ".done_req"},   {63'd0, o_mem_req},    64'd0);
        chk({tag, ".fault"},      {63'd0, o_fault},      64'd0);
        i_mem_gnt = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk({tag, ".resp_drop"}, {63'd0, o_resp_valid}, 64'd0);
    endtask

    task automatic run_fault(input string tag, input logic ld, input logic st,
                             input logic [2:0] f3, input logic [63:0] a);
        drive_req(ld, st, f3, a, 64'hDEAD_BEEF_DEAD_BEEF);
        #1 chk({tag, ".req_idle"}, {63'd0, o_mem_req}, 64'd0);
        @(negedge clk);
        chk({tag, ".resp"},  {63'd0, o_resp_valid}, 64'd1);
        chk({tag, ".fault"}, {63'd0, o_fault},      64'd1);
        chk({tag, ".req"},   {63'd0, o_mem_req},    64'd0);
        chk({tag, ".ldata"}, o_load_data,           64'd0);
        chk({tag, ".stall"}, {63'd0, o_stall},      64'd0);
        idle_inputs();
        @(negedge clk);
        chk({tag, ".resp_drop"}, {63'd0, o_resp_valid}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = '0;
        #1 all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // LW sign-extends upper word; grant one cycle late
        run_load("lw_1004", 3'b010, 64'h1004, 1, 64'h8000_0001_1234_5678, 64'hFFFF_FFFF_8000_0001);
        // Byte-lane stores and a full doubleword with grant withheld five cycles
        run_store("sb_2003", 3'b000, 64'h2003, 64'h0000_0000_0000_00AB, 0, 8'h08, 64'h0000_0000_AB00_0000);
        run_store("sh_2006", 3'b001, 64'h2006, 64'h0000_0000_0000_1234, 0, 8'hC0, 64'h1234_0000_0000_0000);
        run_store("sw_2004", 3'b010, 64'h2004, 64'h0000_0000_CAFE_F00D, 0, 8'hF0, 64'hCAFE_F00D_0000_0000);
        run_store("sd_4008", 3'b011, 64'h4008, 64'h0123_4567_89AB_CDEF, 5, 8'hFF, 64'h0123_4567_89AB_CDEF);

        // Faults: misaligned, illegal widths, both op types
        run_fault("f_ld_3004", 1'b1, 1'b0, 3'b011, 64'h3004);
        run_fault("f_lw_1002", 1'b1, 1'b0, 3'b010, 64'h1002);
        run_fault("f_lh_1001", 1'b1, 1'b0, 3'b001, 64'h1001);
        run_fault("f_l111",    1'b1, 1'b0, 3'b111, 64'h1000);
        run_fault("f_s100",    1'b0, 1'b1, 3'b100, 64'h1000);
        run_fault("f_sh_1003", 1'b0, 1'b1, 3'b001, 64'h1003);
        run_fault("f_both",    1'b1, 1'b1, 3'b000, 64'h1000);

        // LBU aborted by reset in WAIT, then stale rvalid/gnt after release
        drive_req(1'b1, 1'b0, 3'b100, 64'h5001, 64'd0);
        @(negedge clk);
        chk("rst_abort.req", {63'd0, o_mem_req}, 64'd1);
        i_mem_gnt = 1'b1;
        @(negedge clk);
        chk("rst_abort.wait_stall", {63'd0, o_stall}, 64'd1);
        i_mem_gnt = 1'b0;
        idle_inputs();
        rst = 1'b1;
        #1 all_zero("rst_abort.in_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        i_mem_rvalid = 1'b1;
        i_mem_gnt    = 1'b1;
        i_mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        all_zero("rst_abort.stale");
        i_mem_rvalid = 1'b0;
        i_mem_gnt    = 1'b0;
        @(negedge clk);
        all_zero("rst_abort.after");

        // Upper halfword extraction, zero- and sign-extended; byte 7; doubleword
        run_load("lhu_10e", 3'b101, 64'h10E, 0, 64'hF00D_1234_5678_9ABC, 64'h0000_0000_0000_F00D);
        run_load("lh_10e",  3'b001, 64'h10E, 0, 64'hF00D_1234_5678_9ABC, 64'hFFFF_FFFF_FFFF_F00D);
        run_load("lb_107",  3'b000, 64'h107, 0, 64'h80FF_FFFF_FFFF_FF7F, 64'hFFFF_FFFF_FFFF_FF80);
        run_load("lwu_104", 3'b110, 64'h104, 0, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
        run_load("ld_108",  3'b011, 64'h108, 2, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
